// File: rtl/deskew.sv
// Re-aligns the staggered output lanes of a systolic array into one vector per clock,
// tagging each aligned vector with valid and end-of-burst markers.
module deskew #(
    parameter int data_size = 16,
    parameter int size      = 4,
    parameter int cycle     = 1,
    parameter int burst_len = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      valid_in,
    input  logic [data_size*size-1:0] bus_in,
    output logic                      valid_out,
    output logic                      last_out,
    output logic [data_size*size-1:0] bus_out
);

    localparam int tag_depth = (size - 1) * cycle + 1;
    localparam int cnt_w     = (burst_len > 1) ? $clog2(burst_len) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(burst_len - 1);

    logic [tag_depth-1:0] tag_q, tag_d;
    logic [cnt_w-1:0]     cnt_q, cnt_d;

    // Early lanes wait longer so every lane of a vector reaches the output on the same edge.
    for (genvar i = 0; i < size; i++) begin : g_lane
        localparam int depth = (size - 1 - i) * cycle + 1;

        logic [data_size-1:0] lane_q [depth];
        logic [data_size-1:0] lane_d [depth];

        always_comb begin
            lane_d = lane_q;
            if (en) begin
                lane_d[0] = bus_in[data_size*i +: data_size];
                for (int j = 1; j < depth; j++) begin
                    lane_d[j] = lane_q[j-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int j = 0; j < depth; j++) begin
                    lane_q[j] <= '0;
                end
            end else begin
                lane_q <= lane_d;
            end
        end

        assign bus_out[data_size*i +: data_size] = lane_q[depth-1];
    end

    always_comb begin
        tag_d = tag_q;
        cnt_d = cnt_q;
        if (en) begin
            tag_d[0] = valid_in;
            for (int j = 1; j < tag_depth; j++) begin
                tag_d[j] = tag_q[j-1];
            end
            if (tag_q[tag_depth-1]) begin
                cnt_d = (cnt_q == cnt_last) ? '0 : cnt_q + cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

    // Gating with en keeps a stalled beat from being seen (or counted) twice downstream.
    assign valid_out = en & tag_q[tag_depth-1];
    assign last_out  = valid_out & (cnt_q == cnt_last);

endmodule

// File: tb/tb_deskew.sv
// Directed bench for deskew: instance A (size 4, cycle 1, burst 3) and
// instance B (size 3, cycle 2, burst 1) driven cycle by cycle with hand-derived expectations.
module tb_deskew;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        a_valid_in, a_valid_out, a_last_out;
    logic [63:0] a_bus_in, a_bus_out;
    logic        b_valid_in, b_valid_out, b_last_out;
    logic [47:0] b_bus_in, b_bus_out;

    int n_checks = 0;
    int n_fails  = 0;
    bit vmask [0:31];

    always #5 clk = ~clk;

    deskew #(.data_size(16), .size(4), .cycle(1), .burst_len(3)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(a_valid_in), .bus_in(a_bus_in),
        .valid_out(a_valid_out), .last_out(a_last_out), .bus_out(a_bus_out)
    );

    deskew #(.data_size(16), .size(3), .cycle(2), .burst_len(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(b_valid_in), .bus_in(b_bus_in),
        .valid_out(b_valid_out), .last_out(b_last_out), .bus_out(b_bus_out)
    );

    task automatic check_output(input string tag, input int cyc,
                                input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] elem(input logic [15:0] base, input int k, input int i);
        return base + 16'(k * 256) + 16'(i);
    endfunction

    // Lane i carries the element of the vector whose lane 0 appeared i steps earlier.
    function automatic logic [63:0] a_skewed(input logic [15:0] base, input int t);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            if (t - i >= 0 && t - i < 32 && vmask[t-i]) r[16*i +: 16] = elem(base, t - i, i);
        end
        return r;
    endfunction

    function automatic logic [47:0] b_skewed(input logic [15:0] base, input int t);
        logic [47:0] r = '0;
        for (int i = 0; i < 3; i++) begin
            if (t - 2*i >= 0 && t - 2*i < 32 && vmask[t-2*i]) r[16*i +: 16] = elem(base, t - 2*i, i);
        end
        return r;
    endfunction

    function automatic logic [63:0] a_aligned(input logic [15:0] base, input int k);
        return {elem(base, k, 3), elem(base, k, 2), elem(base, k, 1), elem(base, k, 0)};
    endfunction

    task automatic clear_mask();
        for (int i = 0; i < 32; i++) vmask[i] = 1'b0;
    endtask

    task automatic apply_stimulus(input bit rst_v, input bit en_v, input bit av, input logic [63:0] ab,
                                  input bit bv, input logic [47:0] bb);
        rst_n = rst_v; en = en_v;
        a_valid_in = av; a_bus_in = ab;
        b_valid_in = bv; b_bus_in = bb;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("rst_a_valid", -1, 64'(a_valid_out), 64'd0);
        check_output("rst_a_last",  -1, 64'(a_last_out),  64'd0);
        check_output("rst_a_bus",   -1, a_bus_out,        64'd0);
        check_output("rst_b_valid", -1, 64'(b_valid_out), 64'd0);
        check_output("rst_b_bus",   -1, 64'(b_bus_out),   64'd0);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] exp_bus;
        bit          exp_v, exp_l;
        int          e;

        // Single vector, size 4 / cycle 1: aligned at cycle 4 only.
        do_reset();
        clear_mask(); vmask[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b1, 1'b1, vmask[c], a_skewed(16'h1000, c), 1'b0, '0);
            #1;
            check_output("single_valid", c, 64'(a_valid_out), 64'(c == 4));
            check_output("single_last",  c, 64'(a_last_out),  64'd0);
            check_output("single_bus",   c, a_bus_out, (c == 4) ? 64'h1003_1002_1001_1000 : 64'd0);
            step();
        end

        // Seven back-to-back vectors with burst_len 3.
        do_reset();
        clear_mask(); for (int k = 0; k < 7; k++) vmask[k] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            apply_stimulus(1'b1, 1'b1, vmask[c], a_skewed(16'h0000, c), 1'b0, '0);
            #1;
            exp_v   = (c >= 4 && c <= 10);
            exp_l   = (c == 6 || c == 9);
            exp_bus = exp_v ? a_aligned(16'h0000, c - 4) : 64'd0;
            check_output("stream_valid", c, 64'(a_valid_out), 64'(exp_v));
            check_output("stream_last",  c, 64'(a_last_out),  64'(exp_l));
            check_output("stream_bus",   c, a_bus_out, exp_bus);
            step();
        end

        // Stall during cycles 2-3 while the vector is in flight.
        do_reset();
        clear_mask(); vmask[0] = 1'b1;
        e = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2 || c == 3) en = 1'b0;
            else apply_stimulus(1'b1, 1'b1, vmask[e], a_skewed(16'h1000, e), 1'b0, '0);
            #1;
            check_output("stall_valid", c, 64'(a_valid_out), 64'(c == 6));
            check_output("stall_last",  c, 64'(a_last_out),  64'd0);
            check_output("stall_bus",   c, a_bus_out, (c == 6) ? 64'h1003_1002_1001_1000 : 64'd0);
            if (en) e++;
            step();
        end

        // Stall while a beat sits at the output: it must not be counted toward last_out.
        do_reset();
        clear_mask(); vmask[0] = 1'b1; vmask[1] = 1'b1; vmask[2] = 1'b1;
        e = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) en = 1'b0;
            else apply_stimulus(1'b1, 1'b1, vmask[e], a_skewed(16'h0000, e), 1'b0, '0);
            #1;
            exp_v   = (c == 4 || c == 6 || c == 7);
            exp_l   = (c == 7);
            case (c)
                4:       exp_bus = 64'h0003_0002_0001_0000;
                5, 6:    exp_bus = 64'h0103_0102_0101_0100;
                7:       exp_bus = 64'h0203_0202_0201_0200;
                default: exp_bus = 64'd0;
            endcase
            check_output("ostall_valid", c, 64'(a_valid_out), 64'(exp_v));
            check_output("ostall_last",  c, 64'(a_last_out),  64'(exp_l));
            check_output("ostall_bus",   c, a_bus_out, exp_bus);
            if (en) e++;
            step();
        end

        // Reset at cycle 5 drops vector 2 and the valid_in seen during reset.
        do_reset();
        clear_mask();
        vmask[0] = 1'b1; vmask[1] = 1'b1; vmask[2] = 1'b1;
        vmask[7] = 1'b1; vmask[8] = 1'b1; vmask[9] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            apply_stimulus(c != 5, 1'b1, (c == 5) ? 1'b1 : vmask[c], a_skewed(16'h0000, c), 1'b0, '0);
            #1;
            exp_v   = (c == 4 || c == 5 || c == 11 || c == 12 || c == 13);
            exp_l   = (c == 13);
            exp_bus = exp_v ? a_aligned(16'h0000, c - 4) : 64'd0;
            check_output("rstmid_valid", c, 64'(a_valid_out), 64'(exp_v));
            check_output("rstmid_last",  c, 64'(a_last_out),  64'(exp_l));
            check_output("rstmid_bus",   c, a_bus_out, exp_bus);
            step();
        end

        // size 3 / cycle 2 / burst_len 1: latency 5, last_out on every valid beat.
        do_reset();
        clear_mask(); vmask[0] = 1'b1; vmask[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, '0, vmask[c], b_skewed(16'h2000, c));
            #1;
            exp_v = (c == 5 || c == 6);
            case (c)
                5:       exp_bus = 64'h0000_2002_2001_2000;
                6:       exp_bus = 64'h0000_2102_2101_2100;
                default: exp_bus = 64'd0;
            endcase
            check_output("c2_valid", c, 64'(b_valid_out), 64'(exp_v));
            check_output("c2_last",  c, 64'(b_last_out),  64'(exp_v));
            check_output("c2_bus",   c, 64'(b_bus_out),   exp_bus);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
